// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Writeback mux, 32x32 register file with write-before-read bypass,
//            and optional retired-instruction counter (macro WB_INSTRET_EN).
// Revision : 1.0
// ============================================================================
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        wdt_reset,
  input  logic        w_enW,
  input  logic [1:0]  WBSelW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ALU_OpW,
  input  logic [31:0] memop,
  input  logic [31:0] PCW_4,
  input  logic [31:0] Instruction_WB,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] wb_data,
  output logic [63:0] instret
);

  localparam logic [1:0] c_SEL_ALU = 2'b00;
  localparam logic [1:0] c_SEL_MEM = 2'b01;
  localparam logic [1:0] c_SEL_PC4 = 2'b10;

  logic [31:0] regs_q [32];
  logic        w_wr_en;

  always_comb begin
    wb_data = 32'h0;
    case (WBSelW)
      c_SEL_ALU: wb_data = ALU_OpW;
      c_SEL_MEM: wb_data = memop;
      c_SEL_PC4: wb_data = PCW_4;
      default:   wb_data = 32'h0;
    endcase
  end

  assign w_wr_en = w_enW && (RDW != 5'd0);

  // Entry 0 is only ever cleared, so it stays constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (w_wr_en) begin
      regs_q[RDW] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = 32'h0;
    if (rs1_addr != 5'd0) begin
      rs1_data = (w_wr_en && (rs1_addr == RDW)) ? wb_data : regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = 32'h0;
    if (rs2_addr != 5'd0) begin
      rs2_data = (w_wr_en && (rs2_addr == RDW)) ? wb_data : regs_q[rs2_addr];
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;
  logic [63:0] instret_d;

  always_comb begin
    instret_d = instret_q;
    if (wdt_reset) begin
      instret_d = 64'h0;
    end else if (Instruction_WB != 32'h0) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= 64'h0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{wdt_reset, Instruction_WB};
  assign instret           = 64'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Directed table-driven bench for wb_stage plus counter/reset sequences.
// Revision : 1.0
// ============================================================================
module tb_wb_stage;

`ifdef WB_INSTRET_EN
  localparam bit c_HAS_CNT = 1'b1;
`else
  localparam bit c_HAS_CNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wdt_reset;
  logic        w_enW;
  logic [1:0]  WBSelW;
  logic [4:0]  RDW;
  logic [31:0] ALU_OpW;
  logic [31:0] memop;
  logic [31:0] PCW_4;
  logic [31:0] Instruction_WB;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic [63:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .wdt_reset      (wdt_reset),
    .w_enW          (w_enW),
    .WBSelW         (WBSelW),
    .RDW            (RDW),
    .ALU_OpW        (ALU_OpW),
    .memop          (memop),
    .PCW_4          (PCW_4),
    .Instruction_WB (Instruction_WB),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .wb_data        (wb_data),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp_wb;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wdt_reset      = 1'b0;
    w_enW          = 1'b0;
    WBSelW         = 2'b00;
    RDW            = 5'd0;
    ALU_OpW        = 32'h0;
    memop          = 32'h0;
    PCW_4          = 32'h0;
    Instruction_WB = 32'h0;
    rs1_addr       = 5'd0;
    rs2_addr       = 5'd0;
  endtask

  logic [31:0] ret_pat [13];
  logic [63:0] exp_cnt;

  initial begin
    // en sel rd alu mem pc4 ra1 ra2 | wb rs1 rs2 ; rows run back to back
    vecs[0]  = '{1'b1, 2'b01, 5'd5,  32'h0,        32'hDEADBEEF, 32'h0, 5'd5,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 5'd5,  32'h1111,     32'h0,        32'h0, 5'd5,  5'd5,  32'h1111,     32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'b00, 5'd0,  32'h1234,     32'h0,        32'h0, 5'd0,  5'd0,  32'h1234,     32'h0,        32'h0};
    vecs[3]  = '{1'b0, 2'b00, 5'd0,  32'h1234,     32'h0,        32'h0, 5'd0,  5'd5,  32'h1234,     32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b0, 2'b00, 5'd3,  32'h1,        32'h2,        32'h3, 5'd3,  5'd5,  32'h1,        32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b0, 2'b01, 5'd3,  32'h1,        32'h2,        32'h3, 5'd3,  5'd5,  32'h2,        32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b0, 2'b10, 5'd3,  32'h1,        32'h2,        32'h3, 5'd3,  5'd5,  32'h3,        32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b0, 2'b11, 5'd3,  32'h1,        32'h2,        32'h3, 5'd3,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b1, 2'b10, 5'd9,  32'h1,        32'h2,        32'h3, 5'd9,  5'd9,  32'h3,        32'h3,        32'h3};
    vecs[9]  = '{1'b1, 2'b11, 5'd9,  32'h1,        32'h2,        32'h3, 5'd9,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF};
    vecs[10] = '{1'b1, 2'b00, 5'd5,  32'hCAFEF00D, 32'h0,        32'h0, 5'd9,  5'd5,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
    vecs[11] = '{1'b0, 2'b00, 5'd5,  32'h0,        32'h0,        32'h0, 5'd5,  5'd9,  32'h0,        32'hCAFEF00D, 32'h0};
    vecs[12] = '{1'b0, 2'b00, 5'd31, 32'h77,       32'h0,        32'h0, 5'd31, 5'd31, 32'h77,       32'h0,        32'h0};
    vecs[13] = '{1'b1, 2'b00, 5'd31, 32'h77,       32'h0,        32'h0, 5'd31, 5'd31, 32'h77,       32'h77,       32'h77};
    vecs[14] = '{1'b0, 2'b00, 5'd0,  32'h0,        32'h0,        32'h0, 5'd31, 5'd5,  32'h0,        32'h77,       32'hCAFEF00D};

    ret_pat = '{32'h13, 32'h33, 32'h0, 32'h23, 32'h63, 32'h0, 32'h6F,
                32'h13, 32'h0, 32'h37, 32'h17, 32'h03, 32'h67};

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    #1;
    chk("reset_rs1", {32'h0, rs1_data}, 64'h0);
    chk("reset_rs2", {32'h0, rs2_data}, 64'h0);
    chk("reset_instret", instret, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      w_enW    = vecs[i].en;
      WBSelW   = vecs[i].sel;
      RDW      = vecs[i].rd;
      ALU_OpW  = vecs[i].alu;
      memop    = vecs[i].mem;
      PCW_4    = vecs[i].pc4;
      rs1_addr = vecs[i].ra1;
      rs2_addr = vecs[i].ra2;
      #1;
      chk($sformatf("vec%0d_wb", i),  {32'h0, wb_data},  {32'h0, vecs[i].exp_wb});
      chk($sformatf("vec%0d_rs1", i), {32'h0, rs1_data}, {32'h0, vecs[i].exp_rs1});
      chk($sformatf("vec%0d_rs2", i), {32'h0, rs2_data}, {32'h0, vecs[i].exp_rs2});
    end

    // Retirement counting: 10 instructions with 3 bubbles, independent of w_enW.
    @(negedge clk);
    idle_inputs();
    wdt_reset = 1'b1;
    @(negedge clk);
    wdt_reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      Instruction_WB = ret_pat[i];
      @(negedge clk);
    end
    Instruction_WB = 32'h0;
    #1;
    exp_cnt = c_HAS_CNT ? 64'd10 : 64'd0;
    chk("instret_10", instret, exp_cnt);

    // Watchdog clear beats a retirement; a simultaneous register write lands.
    @(negedge clk);
    wdt_reset      = 1'b1;
    Instruction_WB = 32'h13;
    w_enW          = 1'b1;
    RDW            = 5'd12;
    ALU_OpW        = 32'hABCD;
    @(negedge clk);
    idle_inputs();
    rs1_addr = 5'd12;
    #1;
    chk("wdt_clear", instret, 64'h0);
    chk("wdt_write_kept", {32'h0, rs1_data}, 64'hABCD);
    Instruction_WB = 32'h13;
    @(negedge clk);
    Instruction_WB = 32'h0;
    #1;
    exp_cnt = c_HAS_CNT ? 64'd1 : 64'd0;
    chk("instret_resume", instret, exp_cnt);

`ifdef WB_INSTRET_EN
    @(negedge clk);
    dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("instret_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    Instruction_WB = 32'h13;
    @(negedge clk);
    Instruction_WB = 32'h0;
    #1;
    chk("instret_wrap", instret, 64'h0);
`endif

    // Asynchronous reset clears state with no clock edge and discards writes.
    @(negedge clk);
    Instruction_WB = 32'h13;
    w_enW          = 1'b1;
    RDW            = 5'd7;
    ALU_OpW        = 32'hA5A5A5A5;
    @(posedge clk);
    #2;
    idle_inputs();
    rs2_addr = 5'd7;
    #1;
    chk("pre_rst_rs2", {32'h0, rs2_data}, 64'hA5A5A5A5);
    rst = 1'b1;
    #1;
    chk("async_rst_rs2", {32'h0, rs2_data}, 64'h0);
    chk("async_rst_rs1", {32'h0, rs1_data}, 64'h0);
    chk("async_rst_instret", instret, 64'h0);
    w_enW          = 1'b1;
    RDW            = 5'd7;
    WBSelW         = 2'b01;
    memop          = 32'h5555;
    Instruction_WB = 32'h13;
    rs1_addr       = 5'd3;
    #1;
    chk("rst_wb_comb", {32'h0, wb_data}, 64'h5555);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    rs2_addr = 5'd7;
    #1;
    chk("rst_write_blocked", {32'h0, rs2_data}, 64'h0);
    chk("rst_count_blocked", instret, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port wdt_reset  input  1  watchdog soft reset, sampled synchronously.
REQ-004 SHALL have port w_enW  input  1  register-file write enable from MEM/WB register.
REQ-005 SHALL have port WBSelW  input  2  writeback source select.
REQ-006 SHALL have port RDW  input  5  destination register index.
REQ-007 SHALL have ports ALU_OpW, memop, PCW_4  input  32 each  ALU result, load data, PC+4.
REQ-008 SHALL have port Instruction_WB  input  32  retiring instruction; 32'h0 = bubble.
REQ-009 SHALL have ports rs1_addr, rs2_addr  input  5 each  decode-stage read addresses.
REQ-010 SHALL have ports rs1_data, rs2_data  output  32 each  decode-stage read data.
REQ-011 SHALL have port wb_data  output  32  selected writeback value, combinational.
REQ-012 SHALL have port instret  output  64  retired-instruction count (Configuration).

Function
REQ-013 SHALL drive wb_data: WBSelW 00 -> ALU_OpW, 01 -> memop, 10 -> PCW_4, 11 -> 32'h0.
REQ-014 SHALL hold a 32x32 register file; x0 reads 0 always and is never written.
REQ-015 SHALL write wb_data to reg[RDW] on rising clk when w_enW=1 and RDW!=0; write visible to registered state next cycle.
REQ-016 SHALL read rs1_data/rs2_data combinationally, zero-latency.
REQ-017 SHALL bypass: if rsN_addr==RDW, RDW!=0, w_enW=1, rsN_data = wb_data in same cycle (write-before-read semantics).
REQ-018 SHALL return 0 for rsN_addr==0 regardless of bypass conditions.
REQ-019 SHALL treat a retirement as any cycle with Instruction_WB!=0, independent of w_enW (stores/branches retire).
REQ-020 SHALL increment instret by 1 per retirement, 64-bit unsigned, wrapping 2^64-1 -> 0.
REQ-021 SHALL, when wdt_reset=1 at a rising edge, load instret with 0; wdt_reset has priority over a simultaneous retirement.
REQ-022 SHALL leave register file contents unaffected by wdt_reset; a simultaneous register write still completes.
REQ-023 SHALL make the two read ports independent; both may address the same register or the write target.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear all 31 writable registers and instret to 0.
REQ-025 SHALL block all writes and counting while rst=1; rst asserted mid-write discards that write.
REQ-026 SHALL resume normal operation on the first rising clk after rst deasserts; combinational outputs follow inputs throughout.

Configuration
REQ-027 SHALL compile the retirement counter only when macro WB_INSTRET_EN is defined.
REQ-028 SHALL, without WB_INSTRET_EN, tie instret to 64'h0, omit counter flops, and ignore wdt_reset; all other behaviour unchanged.

Verification
REQ-029 SHALL cover: w_enW=1, RDW=5, WBSelW=01, memop=32'hDEADBEEF, rs1_addr=5 -> rs1_data=DEADBEEF same cycle; reg[5]=DEADBEEF next cycle with w_enW=0.
REQ-030 SHALL cover: w_enW=1, RDW=0, ALU_OpW=32'h1234 -> rs1_addr=0 reads 0 same and following cycle.
REQ-031 SHALL cover: WBSelW 00/01/10/11 with ALU=1, mem=2, PC+4=3 -> wb_data 1,2,3,0.
REQ-032 SHALL cover: 10 cycles non-zero Instruction_WB with 3 zero bubbles interleaved -> instret=10; wdt_reset pulsed with retirement -> instret=0 next cycle.
REQ-033 SHALL cover (WB_INSTRET_EN, counter forced to 64'hFFFF_FFFF_FFFF_FFFF) one retirement -> instret=0.
REQ-034 SHALL cover: write reg[7]=32'hA5A5A5A5, assert rst mid-cycle -> rs2_addr=7 reads 0 immediately without clock edge; instret=0.
